// File: rtl/rsa_modexp_8bit.sv
// Sequential modular exponentiation (base^exponent mod modulus) using square-and-multiply
// with bit-serial interleaved modular multiplication; no multiplier, no '%' operator.
module rsa_modexp_8bit #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exponent,
  input  logic [W-1:0] modulus,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result
);

  localparam int unsigned IW = $clog2(W);

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    MUL_R,
    MUL_B,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [W-1:0]  b;
  logic [W-1:0]  r;
  logic [W-1:0]  e;
  logic [W-1:0]  n;
  logic [W:0]    acc;
  logic [IW-1:0] i;
  logic [IW-1:0] k;
  logic [IW-1:0] i_inc;

  logic          accept;
  logic          mul_last;
  logic [W-1:0]  mul_y;
  logic [W:0]    n9;
  logic [W:0]    x9;
  logic [W:0]    t_dbl;
  logic [W:0]    t_red;
  logic [W:0]    t_add;
  logic [W:0]    t_next;

  // Outputs are registered on the DONE exit, so the pulse cycle is still
  // treated as part of the job: a start seen while done is high is ignored.
  assign accept   = (state == IDLE) && start && !done;
  assign mul_last = (k == '0);
  assign i_inc    = i + 1'b1;
  assign busy     = (state != IDLE) || done;

  // One step of the interleaved multiply; every intermediate stays below 2n.
  always_comb begin
    mul_y  = (state == MUL_R) ? r : b;
    n9     = {1'b0, n};
    x9     = {1'b0, b};
    t_dbl  = acc << 1;
    t_red  = (t_dbl >= n9) ? (t_dbl - n9) : t_dbl;
    t_add  = mul_y[k] ? (t_red + x9) : t_red;
    t_next = (t_add >= n9) ? (t_add - n9) : t_add;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = (modulus == '0) ? DONE : REDUCE;
        end
      end
      REDUCE: begin
        if (b < n) begin
          state_nx = e[0] ? MUL_R : MUL_B;
        end
      end
      MUL_R: begin
        if (mul_last) begin
          state_nx = MUL_B;
        end
      end
      MUL_B: begin
        if (mul_last) begin
          if (i == IW'(W - 1)) begin
            state_nx = DONE;
          end else begin
            state_nx = e[i_inc] ? MUL_R : MUL_B;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b      <= '0;
      r      <= '0;
      e      <= '0;
      n      <= '0;
      acc    <= '0;
      i      <= '0;
      k      <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            b   <= base;
            e   <= exponent;
            n   <= modulus;
            err <= 1'b0;
            r   <= (modulus > W'(1)) ? W'(1) : '0;
            acc <= '0;
            i   <= '0;
            k   <= '1;
          end
        end
        REDUCE: begin
          if (b >= n) begin
            b <= b - n;
          end else begin
            i   <= '0;
            acc <= '0;
            k   <= '1;
          end
        end
        MUL_R: begin
          acc <= t_next;
          k   <= k - 1'b1;
          if (mul_last) begin
            r   <= t_next[W-1:0];
            acc <= '0;
          end
        end
        MUL_B: begin
          acc <= t_next;
          k   <= k - 1'b1;
          if (mul_last) begin
            b   <= t_next[W-1:0];
            acc <= '0;
            if (i != IW'(W - 1)) begin
              i <= i_inc;
            end
          end
        end
        DONE: begin
          done   <= 1'b1;
          result <= r;
          err    <= (n == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_8bit.sv
// Self-checking bench for rsa_modexp_8bit: directed scenarios plus randomized jobs
// checked against a plain-arithmetic model of modular exponentiation and latency.
module tb_rsa_modexp_8bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] base;
  logic [7:0] exponent;
  logic [7:0] modulus;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  rsa_modexp_8bit #(.W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_modexp(input int b, input int e, input int n);
    int acc;
    if (n == 0) return 8'd0;
    acc = 1 % n;
    for (int j = 0; j < e; j++) acc = (acc * b) % n;
    return acc[7:0];
  endfunction

  function automatic int ref_latency(input int b, input int e, input int n);
    if (n == 0) return 1;
    return 1 + (b / n + 1) + 8 * $countones(e[7:0]) + 64;
  endfunction

  // Starts one job and waits (bounded) for its done pulse.
  task automatic run_job(input logic [7:0] bi, input logic [7:0] ei, input logic [7:0] ni,
                         output int lat, output logic [7:0] res, output logic er,
                         output logic busy_early, output logic busy_after);
    lat = -1;
    res = 8'hxx;
    er = 1'bx;
    busy_after = 1'bx;
    @(negedge clk);
    base = bi; exponent = ei; modulus = ni; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_early = busy;
    for (int c = 1; c <= 2000 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        res = result;
        er = err;
      end
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
      busy_after = busy;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err); end
    n_cmp++; if (result !== 8'd0) begin n_bad++; $display("FAIL reset_result got=%0d want=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_encrypt;
    int lat; logic [7:0] res; logic er, be, ba;
    run_job(8'd4, 8'd3, 8'd33, lat, res, er, be, ba);
    n_cmp++; if (lat !== 82) begin n_bad++; $display("FAIL enc_latency got=%0d want=82", lat); end
    n_cmp++; if (res !== 8'd31) begin n_bad++; $display("FAIL enc_result got=%0d want=31", res); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL enc_err got=%b want=0", er); end
    n_cmp++; if (be !== 1'b1) begin n_bad++; $display("FAIL enc_busy_early got=%b want=1", be); end
    n_cmp++; if (ba !== 1'b0) begin n_bad++; $display("FAIL enc_busy_after got=%b want=0", ba); end
  endtask

  task automatic test_decrypt_compare;
    int lat; logic [7:0] res; logic er, be, ba;
    logic eq4, eq5;
    run_job(8'd31, 8'd7, 8'd33, lat, res, er, be, ba);
    // downstream comparator: e = cmp & (a == b), cmp = done
    eq4 = (lat >= 0) && (res == 8'd4);
    eq5 = (lat >= 0) && (res == 8'd5);
    n_cmp++; if (res !== 8'd4) begin n_bad++; $display("FAIL dec_result got=%0d want=4", res); end
    n_cmp++; if (eq4 !== 1'b1) begin n_bad++; $display("FAIL dec_cmp_match got=%b want=1", eq4); end
    n_cmp++; if (eq5 !== 1'b0) begin n_bad++; $display("FAIL dec_cmp_other got=%b want=0", eq5); end
    n_cmp++; if (lat !== ref_latency(31, 7, 33)) begin
      n_bad++; $display("FAIL dec_latency got=%0d want=%0d", lat, ref_latency(31, 7, 33));
    end
  endtask

  task automatic test_edges;
    int lat; logic [7:0] res; logic er, be, ba;
    logic [7:0] cb [5] = '{8'd200, 8'd77, 8'd254, 8'd0, 8'd255};
    logic [7:0] ce [5] = '{8'd0,   8'd5,  8'd2,   8'd9, 8'd255};
    logic [7:0] cn [5] = '{8'd33,  8'd1,  8'd255, 8'd33, 8'd2};
    for (int t = 0; t < 5; t++) begin
      run_job(cb[t], ce[t], cn[t], lat, res, er, be, ba);
      n_cmp++; if (res !== ref_modexp(cb[t], ce[t], cn[t])) begin
        n_bad++; $display("FAIL edge%0d_result got=%0d want=%0d", t, res, ref_modexp(cb[t], ce[t], cn[t]));
      end
      n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL edge%0d_err got=%b want=0", t, er); end
      n_cmp++; if (lat !== ref_latency(cb[t], ce[t], cn[t])) begin
        n_bad++; $display("FAIL edge%0d_latency got=%0d want=%0d", t, lat, ref_latency(cb[t], ce[t], cn[t]));
      end
    end
  endtask

  task automatic test_mod_zero;
    int lat; logic [7:0] res; logic er, be, ba;
    run_job(8'd5, 8'd3, 8'd0, lat, res, er, be, ba);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL modzero_latency got=%0d want=1", lat); end
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL modzero_err got=%b want=1", er); end
    n_cmp++; if (res !== 8'd0) begin n_bad++; $display("FAIL modzero_result got=%0d want=0", res); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL modzero_err_held got=%b want=1", err); end
    run_job(8'd7, 8'd5, 8'd33, lat, res, er, be, ba);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL modzero_err_cleared got=%b want=0", er); end
    n_cmp++; if (res !== ref_modexp(7, 5, 33)) begin
      n_bad++; $display("FAIL modzero_next_result got=%0d want=%0d", res, ref_modexp(7, 5, 33));
    end
  endtask

  task automatic test_start_held;
    int pulses = 0;
    int first = -1;
    logic [7:0] res = 8'h00;
    @(negedge clk);
    base = 8'd10; exponent = 8'd13; modulus = 8'd47; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 400 && first < 0; c++) begin
      @(posedge clk); #1;
      if (done) begin pulses++; first = c; res = result; end
    end
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL held_pulses got=%0d want=1", pulses); end
    n_cmp++; if (first !== ref_latency(10, 13, 47)) begin
      n_bad++; $display("FAIL held_latency got=%0d want=%0d", first, ref_latency(10, 13, 47));
    end
    n_cmp++; if (res !== ref_modexp(10, 13, 47)) begin
      n_bad++; $display("FAIL held_result got=%0d want=%0d", res, ref_modexp(10, 13, 47));
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL held_busy_idle got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [7:0] res; logic er, be, ba;
    int pulses = 0;
    @(negedge clk);
    base = 8'd4; exponent = 8'd3; modulus = 8'd33; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b want=0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL midrst_err got=%b want=0", err); end
    n_cmp++; if (result !== 8'd0) begin n_bad++; $display("FAIL midrst_result got=%0d want=0", result); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midrst_activity got=%0d want=0", pulses); end
    run_job(8'd31, 8'd7, 8'd33, lat, res, er, be, ba);
    n_cmp++; if (res !== 8'd4) begin n_bad++; $display("FAIL midrst_restart got=%0d want=4", res); end
    n_cmp++; if (lat !== ref_latency(31, 7, 33)) begin
      n_bad++; $display("FAIL midrst_latency got=%0d want=%0d", lat, ref_latency(31, 7, 33));
    end
  endtask

  task automatic test_random;
    int lat; logic [7:0] res; logic er, be, ba;
    logic [7:0] rb, re, rn;
    for (int t = 0; t < 24; t++) begin
      rb = 8'($urandom_range(0, 255));
      re = 8'($urandom_range(0, 255));
      rn = (t % 4 == 0) ? 8'($urandom_range(1, 15)) : 8'($urandom_range(1, 255));
      run_job(rb, re, rn, lat, res, er, be, ba);
      n_cmp++; if (res !== ref_modexp(rb, re, rn)) begin
        n_bad++; $display("FAIL rand%0d_result b=%0d e=%0d n=%0d got=%0d want=%0d",
                          t, rb, re, rn, res, ref_modexp(rb, re, rn));
      end
      n_cmp++; if (lat !== ref_latency(rb, re, rn)) begin
        n_bad++; $display("FAIL rand%0d_latency b=%0d e=%0d n=%0d got=%0d want=%0d",
                          t, rb, re, rn, lat, ref_latency(rb, re, rn));
      end
      n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL rand%0d_err got=%b want=0", t, er); end
    end
  endtask

  initial begin
    test_reset;
    test_encrypt;
    test_decrypt_compare;
    test_edges;
    test_mod_zero;
    test_start_held;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
